register_writeback: RTL and testbench
=====================================

REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 Parameter PEND_DEPTH, default 2, sets the ALU pending-write buffer depth (power of two, 2 to 4).
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port mem_write_req / mem_write_addr / mem_write_data, input, 1/5/32 bits: load write-back from the data-memory stage.
REQ-005 Port alu_write_req / alu_write_addr / alu_write_data, input, 1/5/32 bits: ALU write-back.
REQ-006 Port rs1_addr / rs2_addr, input, 5 bits each: read addresses.
REQ-007 Port rs1_value / rs2_value, output, 32 bits each: combinational read data.
REQ-008 Port stall, output, 1 bit: buffer full; upstream holds ALU issue.
REQ-009 Port pending_count, output, 3 bits: number of buffered ALU writes.
REQ-010 Port overflow_err, output, 1 bit: sticky flag for a dropped ALU write.

Function
REQ-011 The block SHALL hold 32 registers of 32 bits; x0 SHALL read 0, and writes to x0 SHALL be discarded and never buffered.
REQ-012 A valid mem write SHALL update the array at the clock edge of the cycle it is presented (latency 1).
REQ-013 If no mem write is present and the buffer is empty, a valid ALU write SHALL update the array directly at the same edge.
REQ-014 Otherwise, a valid ALU write SHALL be pushed into the FIFO buffer.
REQ-015 In any cycle without a valid mem write, the buffer head SHALL be written to the array and popped; push and pop in the same cycle SHALL be allowed.
REQ-016 A mem write and an ALU write to the same address in the same cycle SHALL leave the ALU value as the final register content.
REQ-017 A mem write SHALL invalidate every buffered entry with the same address, because those entries are older; invalidated entries SHALL pop without writing.
REQ-018 rs1_value/rs2_value SHALL return the newest value for the address, in priority order: incoming ALU, then incoming mem, then the youngest valid buffered entry, then the array.
REQ-019 stall SHALL be high exactly when pending_count equals PEND_DEPTH.
REQ-020 An ALU write arriving when the buffer is full and no pop occurs SHALL be dropped, and overflow_err SHALL be set until reset.
REQ-021 Buffer pointers SHALL wrap modulo PEND_DEPTH; pending_count SHALL never exceed PEND_DEPTH or underflow.

Reset
REQ-022 While reset_n is low: all registers SHALL be 0; the buffer SHALL be empty (pending_count 0); stall and overflow_err SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard buffered writes without committing them.
REQ-024 Reading any address during reset SHALL return 0.

Structure
REQ-025 A shared package SHALL hold REG_COUNT=32, REG_ADDR_W=5, XLEN=32 and the zero-register index constant.
REQ-026 The buffer SHALL be one sub-module, wb_pending_fifo, with entries {valid, addr, data}, push/pop ports, count output, and an address-match invalidate port.
REQ-027 The bypass-read mux SHALL be duplicated per read port inside register_writeback.

Verification
REQ-028 ALU write x5=0x1234 with no mem write: rs1_addr=5 reads 0x1234 in the same cycle and from the array the next cycle; pending_count stays 0.
REQ-029 Mem write x3=0xAA and ALU write x4=0xBB in the same cycle: x3=0xAA committed; x4 buffered (pending_count=1); x4 reads 0xBB via bypass; x4 commits the next idle cycle.
REQ-030 Mem writes on 3 consecutive cycles alongside ALU writes, with PEND_DEPTH=2: stall rises after 2 pushes; the third ALU write is dropped and overflow_err=1.
REQ-031 Buffered ALU x7=0x1, then mem write x7=0x2: the entry is invalidated, and x7 ends as 0x2.
REQ-032 Same-cycle mem x9=0x10 and ALU x9=0x20: rs1 reads 0x20; x9 ends as 0x20. A write to x0 of 0xFFFF: x0 reads 0.
REQ-033 reset_n pulsed low while pending_count=2: pending_count=0, all registers read 0, and no buffered data is committed.

Source files
------------

// File: rtl/register_writeback_pkg.sv
// Shared definitions for the register write-back block.
//   REG_COUNT  : number of architectural registers
//   REG_ADDR_W : register address width
//   XLEN       : register data width
//   ZERO_REG   : index of the hard-wired zero register
//   wb_entry_t : one pending ALU write {valid, addr, data}
package register_writeback_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/register_writeback_pending_fifo.sv
// wb_pending_fifo: small FIFO of ALU writes waiting for a free register-file
// write port.
//   clk, reset_n            : clock, asynchronous active-low reset
//   push/push_addr/push_data: enqueue a new valid entry at the tail
//   pop                     : drop the head entry (ignored when empty)
//   inval_req/inval_addr    : clear the valid bit of every stored entry whose
//                             address matches (the slot being pushed this
//                             cycle is younger and is not affected)
//   count                   : number of occupied slots (valid or not)
//   rd_ptr                  : slot index of the head (oldest) entry
//   head                    : head entry
//   entries                 : all slots, for the bypass read muxes
module wb_pending_fifo
  import register_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  inval_req,
  input  logic [REG_ADDR_W-1:0] inval_addr,
  output logic [2:0]            count,
  output logic [PTR_W-1:0]      rd_ptr,
  output wb_entry_t             head,
  output wb_entry_t             entries [DEPTH]
);

  wb_entry_t          slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [2:0]         count_q;
  logic               is_full;
  logic               is_empty;
  logic               push_ok;
  logic               pop_ok;

  assign is_full  = (count_q == 3'(DEPTH));
  assign is_empty = (count_q == 3'd0);
  // A full FIFO can still accept a push when the head leaves the same cycle.
  assign push_ok  = push && (!is_full || (pop && !is_empty));
  assign pop_ok   = pop && !is_empty;

  // NOTE: every piece of sequential state is updated with non-blocking
  // assignments so all flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the slots are tiny, so they are reset too; this keeps the
      // bypass muxes free of X even for slots outside the occupied range.
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (inval_req) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (slots[i].addr == inval_addr) begin
            slots[i].valid <= 1'b0;
          end
        end
      end
      // Later assignment wins, so a fresh push is never hit by the invalidate.
      if (push_ok) begin
        slots[wr_ptr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign head    = slots[rd_ptr_q];
  assign entries = slots;

endmodule

// File: rtl/register_writeback.sv
// register_writeback: 32x32 register file with two write sources.
// The memory (load) write always owns the single array write port; ALU
// writes go straight to the array when the port is free and nothing is
// queued, otherwise they wait in wb_pending_fifo and drain in idle cycles.
//   clk, reset_n                       : clock, async active-low reset
//   mem_write_req/addr/data            : load write-back
//   alu_write_req/addr/data            : ALU write-back
//   rs1_addr/rs2_addr                  : read addresses
//   rs1_value/rs2_value                : combinational read data with bypass
//   stall                              : pending buffer full
//   pending_count                      : buffered ALU writes
//   overflow_err                       : sticky, an ALU write was dropped
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int PEND_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_write_req,
  input  logic [REG_ADDR_W-1:0] mem_write_addr,
  input  logic [XLEN-1:0]       mem_write_data,
  input  logic                  alu_write_req,
  input  logic [REG_ADDR_W-1:0] alu_write_addr,
  input  logic [XLEN-1:0]       alu_write_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_value,
  output logic [XLEN-1:0]       rs2_value,
  output logic                  stall,
  output logic [2:0]            pending_count,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(PEND_DEPTH);

  logic [XLEN-1:0]       regs [REG_COUNT];

  logic                  mem_valid;
  logic                  alu_valid;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  alu_direct;
  logic                  buf_pop;
  logic                  buf_push;
  logic                  alu_drop;
  logic [2:0]            buf_count;
  logic [PTR_W-1:0]      buf_rd_ptr;
  wb_entry_t             buf_head;
  wb_entry_t             buf_entries [PEND_DEPTH];

  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  // Writes to x0 are filtered here so they never reach the array or buffer.
  assign mem_valid  = mem_write_req && (mem_write_addr != ZERO_REG);
  assign alu_valid  = alu_write_req && (alu_write_addr != ZERO_REG);
  assign buf_empty  = (buf_count == 3'd0);
  assign buf_full   = (buf_count == 3'(PEND_DEPTH));
  assign alu_direct = alu_valid && !mem_valid && buf_empty;
  // The head drains whenever the load path leaves the write port free.
  assign buf_pop    = !mem_valid && !buf_empty;
  assign buf_push   = alu_valid && !alu_direct && (!buf_full || buf_pop);
  assign alu_drop   = alu_valid && !alu_direct && buf_full && !buf_pop;

  wb_pending_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pending (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (buf_push),
    .push_addr  (alu_write_addr),
    .push_data  (alu_write_data),
    .pop        (buf_pop),
    .inval_req  (mem_valid),
    .inval_addr (mem_write_addr),
    .count      (buf_count),
    .rd_ptr     (buf_rd_ptr),
    .head       (buf_head),
    .entries    (buf_entries)
  );

  // Single array write port. alu_direct and buf_pop are mutually exclusive
  // (one needs an empty buffer, the other a non-empty one).
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (mem_valid) begin
      wr_en   = 1'b1;
      wr_addr = mem_write_addr;
      wr_data = mem_write_data;
    end else if (alu_direct) begin
      wr_en   = 1'b1;
      wr_addr = alu_write_addr;
      wr_data = alu_write_data;
    end else if (buf_pop && buf_head.valid) begin
      // Invalidated heads pop without touching the array.
      wr_en   = 1'b1;
      wr_addr = buf_head.addr;
      wr_data = buf_head.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
    end else if (alu_drop) begin
      overflow_err <= 1'b1;
    end
  end

  assign stall         = buf_full;
  assign pending_count = buf_count;

  // One bypass mux per read port. Priority, lowest to highest: array,
  // buffered entries oldest to youngest, incoming mem, incoming ALU.
  for (genvar p = 0; p < 2; p++) begin : g_read_port
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       value;
    logic [PTR_W-1:0]      slot;

    assign addr = (p == 0) ? rs1_addr : rs2_addr;

    always_comb begin
      value = regs[addr];
      slot  = '0;
      for (int k = 0; k < PEND_DEPTH; k++) begin
        slot = buf_rd_ptr + PTR_W'(k);
        if ((3'(k) < buf_count) && buf_entries[slot].valid &&
            (buf_entries[slot].addr == addr)) begin
          value = buf_entries[slot].data;
        end
      end
      if (mem_valid && (mem_write_addr == addr)) begin
        value = mem_write_data;
      end
      if (alu_valid && (alu_write_addr == addr)) begin
        value = alu_write_data;
      end
      if (!reset_n || (addr == ZERO_REG)) begin
        value = '0;
      end
    end
  end

  assign rs1_value = g_read_port[0].value;
  assign rs2_value = g_read_port[1].value;

endmodule

// File: tb/tb_register_writeback.sv
// Self-checking bench for register_writeback: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_register_writeback;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset_n;
  logic        mem_write_req;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        alu_write_req;
  logic [4:0]  alu_write_addr;
  logic [31:0] alu_write_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        stall;
  logic [2:0]  pending_count;
  logic        overflow_err;

  register_writeback #(.PEND_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_write_req  (mem_write_req),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .alu_write_req  (alu_write_req),
    .alu_write_addr (alu_write_addr),
    .alu_write_data (alu_write_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_value      (rs1_value),
    .rs2_value      (rs2_value),
    .stall          (stall),
    .pending_count  (pending_count),
    .overflow_err   (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural registers, an ordered list of pending
  // ALU writes (front = oldest) and the sticky drop flag.
  typedef struct {
    bit        valid;
    bit [4:0]  addr;
    bit [31:0] data;
  } pend_t;

  pend_t       pend [$];
  logic [31:0] m_regs [32];
  bit          m_ovf;
  bit          in_reset;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (in_reset || a == 5'd0) return 32'd0;
    if (alu_write_req && alu_write_addr == a) return alu_write_data;
    if (mem_write_req && mem_write_addr == a) return mem_write_data;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].valid && pend[i].addr == a) return pend[i].data;
    end
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    pend.delete();
    m_ovf = 1'b0;
  endtask

  // Applies one clock edge of the write-back rules to the model.
  task automatic model_commit();
    bit    mv;
    bit    av;
    bit    was_full;
    bit    direct;
    bit    popped;
    pend_t h;
    pend_t n;
    mv       = mem_write_req && (mem_write_addr != 5'd0);
    av       = alu_write_req && (alu_write_addr != 5'd0);
    was_full = (pend.size() == DEPTH);
    direct   = av && !mv && (pend.size() == 0);
    popped   = 1'b0;
    if (mv) begin
      m_regs[mem_write_addr] = mem_write_data;
      foreach (pend[i]) if (pend[i].addr == mem_write_addr) pend[i].valid = 1'b0;
    end else if (direct) begin
      m_regs[alu_write_addr] = alu_write_data;
    end else if (pend.size() > 0) begin
      h = pend.pop_front();
      popped = 1'b1;
      if (h.valid) m_regs[h.addr] = h.data;
    end
    if (av && !direct) begin
      if (!was_full || popped) begin
        n.valid = 1'b1;
        n.addr  = alu_write_addr;
        n.data  = alu_write_data;
        pend.push_back(n);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit mreq, input logic [4:0] ma, input logic [31:0] md,
                       input bit areq, input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    mem_write_req  = mreq;
    mem_write_addr = ma;
    mem_write_data = md;
    alu_write_req  = areq;
    alu_write_addr = aa;
    alu_write_data = ad;
    rs1_addr       = r1;
    rs2_addr       = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle(input string tag);
    #1;
    check({tag, "/rs1"},   rs1_value, model_read(rs1_addr));
    check({tag, "/rs2"},   rs2_value, model_read(rs2_addr));
    check({tag, "/count"}, 32'(pending_count), 32'(pend.size()));
    check({tag, "/stall"}, 32'(stall), 32'(pend.size() == DEPTH));
    check({tag, "/ovf"},   32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (in_reset) model_reset();
    else model_commit();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n  = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    check("rst/count", 32'(pending_count), 32'd0);
    check("rst/stall", 32'(stall), 32'd0);
    check("rst/ovf",   32'(overflow_err), 32'd0);
    check("rst/rs1",   rs1_value, 32'd0);
    tick();
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    idle(5'd0, 5'd0);
    model_reset();
    @(negedge clk);

    // Reads during reset return 0 even with a write presented to that address.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    pulse_reset();

    // Direct ALU write: bypass this cycle, array next cycle.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
    settle("alu_direct");
    check("alu_direct/bypass", rs1_value, 32'h1234);
    check("alu_direct/count", 32'(pending_count), 32'd0);
    tick();
    idle(5'd5, 5'd0);
    settle("alu_direct_next");
    check("alu_direct/array", rs1_value, 32'h1234);
    check("alu_direct/count2", 32'(pending_count), 32'd0);
    tick();

    // Mem and ALU to different registers in one cycle: ALU write is buffered.
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB, 5'd4, 5'd3);
    settle("split");
    tick();
    idle(5'd4, 5'd3);
    settle("split_buf");
    check("split/count", 32'(pending_count), 32'd1);
    check("split/x4_bypass", rs1_value, 32'hBB);
    check("split/x3", rs2_value, 32'hAA);
    tick();
    idle(5'd4, 5'd3);
    settle("split_drained");
    check("split/count_after", 32'(pending_count), 32'd0);
    check("split/x4_array", rs1_value, 32'hBB);
    tick();

    // Three cycles of mem + ALU traffic: buffer fills, third ALU write drops.
    drive(1'b1, 5'd10, 32'hA10, 1'b1, 5'd13, 32'hB13, 5'd10, 5'd13);
    settle("fill1");
    check("fill1/stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd11, 32'hA11, 1'b1, 5'd14, 32'hB14, 5'd13, 5'd11);
    settle("fill2");
    check("fill2/count", 32'(pending_count), 32'd1);
    tick();
    drive(1'b1, 5'd12, 32'hA12, 1'b1, 5'd15, 32'hB15, 5'd13, 5'd14);
    settle("fill3");
    check("fill3/count", 32'(pending_count), 32'd2);
    check("fill3/stall", 32'(stall), 32'd1);
    tick();
    idle(5'd15, 5'd12);
    settle("drop");
    check("drop/ovf", 32'(overflow_err), 32'd1);
    check("drop/x15", rs1_value, 32'd0);
    tick();
    idle(5'd13, 5'd14);
    settle("drain1");
    tick();
    idle(5'd13, 5'd14);
    settle("drain2");
    check("drain2/x13", rs1_value, 32'hB13);
    check("drain2/x14", rs2_value, 32'hB14);
    check("drain2/ovf_sticky", 32'(overflow_err), 32'd1);
    tick();

    // Buffered x7 is superseded by a later mem write to x7.
    drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd7, 32'h1, 5'd7, 5'd8);
    settle("inv_push");
    tick();
    drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);
    settle("inv_mem");
    tick();
    idle(5'd7, 5'd0);
    settle("inv_pop");
    check("inv/count_stale", 32'(pending_count), 32'd1);
    check("inv/x7_mid", rs1_value, 32'h2);
    tick();
    idle(5'd7, 5'd0);
    settle("inv_done");
    check("inv/x7_final", rs1_value, 32'h2);
    check("inv/count_final", 32'(pending_count), 32'd0);
    tick();

    // Same-cycle mem and ALU to x9: ALU value wins; x0 writes are ignored.
    drive(1'b1, 5'd9, 32'h10, 1'b1, 5'd9, 32'h20, 5'd9, 5'd0);
    settle("same");
    check("same/bypass", rs1_value, 32'h20);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd9);
    settle("x0_write");
    check("x0/read", rs1_value, 32'd0);
    tick();
    idle(5'd9, 5'd0);
    settle("same_final");
    check("same/x9_final", rs1_value, 32'h20);
    check("x0/after", rs2_value, 32'd0);
    tick();

    // Reset with two buffered writes: nothing buffered may be committed.
    pulse_reset();
    drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd20, 32'hA, 5'd20, 5'd22);
    settle("pre_rst1");
    tick();
    drive(1'b1, 5'd23, 32'h23, 1'b1, 5'd21, 32'hB, 5'd21, 5'd23);
    settle("pre_rst2");
    tick();
    drive(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
    settle("pre_rst3");
    check("pre_rst/count", 32'(pending_count), 32'd2);
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      idle(5'(2 * i), 5'(2 * i + 1));
      settle("post_rst");
      check("post_rst/even", rs1_value, 32'd0);
      check("post_rst/odd", rs2_value, 32'd0);
      tick();
    end

    // Randomized traffic on a narrow address range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        settle("rnd");
        tick();
      end
    end

    // Drain and sweep the whole register file.
    for (int i = 0; i < 16; i++) begin
      idle(5'(2 * i), 5'(2 * i + 1));
      settle("sweep");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
